// File: rtl/axis_mldsa_stream_bridge.sv
// Multi-channel AXI-Stream front end for the ML-DSA core: one FIFO per input channel
// and one on the result path, plus per-channel beat counting and frame-length checking.

module axis_mldsa_stream_bridge_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module axis_mldsa_stream_bridge_lane #(
   parameter int DATA_W   = 64,
   parameter int IN_DEPTH = 4,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              rdy_en,
   input  logic              flush,
   input  logic              err_clr,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic [DATA_W-1:0] c_data,
   output logic              c_valid,
   output logic              c_last,
   input  logic              c_ready,
   input  logic [CNT_W-1:0]  exp_beats,
   output logic              len_err,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic              nempty
);
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic [DATA_W:0] rd_word;
   logic [CNT_W:0]  n;
   logic            bad;

   assign s_tready = rdy_en & ~full & ~flush;
   assign push     = s_tvalid & s_tready;
   assign c_valid  = ~empty & ~flush;
   assign pop      = c_valid & c_ready;
   assign c_data   = rd_word[DATA_W-1:0];
   assign c_last   = rd_word[DATA_W] & c_valid;
   assign nempty   = ~empty;

   axis_mldsa_stream_bridge_fifo #(.W(DATA_W+1), .DEPTH(IN_DEPTH)) u_fifo (
      .clk   (clk),
      .resetn(resetn),
      .clr   (flush),
      .push  (push),
      .wdata ({s_tlast, s_tdata}),
      .pop   (pop),
      .rdata (rd_word),
      .full  (full),
      .empty (empty)
   );

   // n is the 1-based position of the beat being accepted; one bit wider so it never wraps.
   assign n   = {1'b0, beat_cnt} + 1'b1;
   assign bad = push && (exp_beats != '0) &&
                (s_tlast ? (n != {1'b0, exp_beats}) : (n == {1'b0, exp_beats}));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)          beat_cnt <= '0;
      else if (flush)       beat_cnt <= '0;
      else if (push) begin
         if (s_tlast)       beat_cnt <= '0;
         else if (~&beat_cnt) beat_cnt <= beat_cnt + 1'b1;
      end
   end

   // A new error outranks a simultaneous clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      len_err <= 1'b0;
      else if (bad)     len_err <= 1'b1;
      else if (err_clr) len_err <= 1'b0;
   end
endmodule

module axis_mldsa_stream_bridge #(
   parameter int DATA_W    = 64,
   parameter int NUM_IN    = 2,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [NUM_IN-1:0][DATA_W-1:0]  s_axis_tdata,
   input  logic [NUM_IN-1:0]              s_axis_tvalid,
   input  logic [NUM_IN-1:0]              s_axis_tlast,
   output logic [NUM_IN-1:0]              s_axis_tready,
   output logic [NUM_IN-1:0][DATA_W-1:0]  core_in_data,
   output logic [NUM_IN-1:0]              core_in_valid,
   output logic [NUM_IN-1:0]              core_in_last,
   input  logic [NUM_IN-1:0]              core_in_ready,
   input  logic [DATA_W-1:0]              core_out_data,
   input  logic                           core_out_valid,
   input  logic                           core_out_last,
   output logic                           core_out_ready,
   output logic [DATA_W-1:0]              m_axis_tdata,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tlast,
   input  logic                           m_axis_tready,
   input  logic [NUM_IN-1:0][CNT_W-1:0]   exp_beats,
   input  logic                           flush,
   input  logic                           err_clr,
   output logic [NUM_IN-1:0]              len_err,
   output logic [NUM_IN-1:0][CNT_W-1:0]   beat_cnt,
   output logic                           busy
);
   logic              rdy_en;
   logic [NUM_IN-1:0] lane_nempty;
   logic              out_full;
   logic              out_empty;
   logic              out_push;
   logic              out_pop;
   logic [DATA_W:0]   out_word;

   // Holds every ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rdy_en <= 1'b0;
      else         rdy_en <= 1'b1;
   end

   for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
      axis_mldsa_stream_bridge_lane #(
         .DATA_W  (DATA_W),
         .IN_DEPTH(IN_DEPTH),
         .CNT_W   (CNT_W)
      ) u_lane (
         .clk      (clk),
         .resetn   (resetn),
         .rdy_en   (rdy_en),
         .flush    (flush),
         .err_clr  (err_clr),
         .s_tdata  (s_axis_tdata[g]),
         .s_tvalid (s_axis_tvalid[g]),
         .s_tlast  (s_axis_tlast[g]),
         .s_tready (s_axis_tready[g]),
         .c_data   (core_in_data[g]),
         .c_valid  (core_in_valid[g]),
         .c_last   (core_in_last[g]),
         .c_ready  (core_in_ready[g]),
         .exp_beats(exp_beats[g]),
         .len_err  (len_err[g]),
         .beat_cnt (beat_cnt[g]),
         .nempty   (lane_nempty[g])
      );
   end

   assign core_out_ready = rdy_en & ~out_full & ~flush;
   assign out_push       = core_out_valid & core_out_ready;
   assign m_axis_tvalid  = ~out_empty & ~flush;
   assign out_pop        = m_axis_tvalid & m_axis_tready;
   assign m_axis_tdata   = out_word[DATA_W-1:0];
   assign m_axis_tlast   = out_word[DATA_W] & m_axis_tvalid;

   axis_mldsa_stream_bridge_fifo #(.W(DATA_W+1), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk   (clk),
      .resetn(resetn),
      .clr   (flush),
      .push  (out_push),
      .wdata ({core_out_last, core_out_data}),
      .pop   (out_pop),
      .rdata (out_word),
      .full  (out_full),
      .empty (out_empty)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) busy <= 1'b0;
      else         busy <= (|lane_nempty) | ~out_empty;
   end
endmodule

// File: tb/tb_axis_mldsa_stream_bridge.sv
// Randomised bench for axis_mldsa_stream_bridge against a queue-based reference model.

module tb_axis_mldsa_stream_bridge;
   localparam int DATA_W    = 64;
   localparam int NUM_IN    = 2;
   localparam int IN_DEPTH  = 4;
   localparam int OUT_DEPTH = 4;
   localparam int CNT_W     = 16;

   logic                          clk = 1'b0;
   logic                          resetn = 1'b0;
   logic [NUM_IN-1:0][DATA_W-1:0] s_axis_tdata;
   logic [NUM_IN-1:0]             s_axis_tvalid;
   logic [NUM_IN-1:0]             s_axis_tlast;
   logic [NUM_IN-1:0]             s_axis_tready;
   logic [NUM_IN-1:0][DATA_W-1:0] core_in_data;
   logic [NUM_IN-1:0]             core_in_valid;
   logic [NUM_IN-1:0]             core_in_last;
   logic [NUM_IN-1:0]             core_in_ready;
   logic [DATA_W-1:0]             core_out_data;
   logic                          core_out_valid;
   logic                          core_out_last;
   logic                          core_out_ready;
   logic [DATA_W-1:0]             m_axis_tdata;
   logic                          m_axis_tvalid;
   logic                          m_axis_tlast;
   logic                          m_axis_tready;
   logic [NUM_IN-1:0][CNT_W-1:0]  exp_beats;
   logic                          flush;
   logic                          err_clr;
   logic [NUM_IN-1:0]             len_err;
   logic [NUM_IN-1:0][CNT_W-1:0]  beat_cnt;
   logic                          busy;

   axis_mldsa_stream_bridge #(
      .DATA_W(DATA_W), .NUM_IN(NUM_IN), .IN_DEPTH(IN_DEPTH),
      .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .resetn(resetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .core_in_data(core_in_data), .core_in_valid(core_in_valid),
      .core_in_last(core_in_last), .core_in_ready(core_in_ready),
      .core_out_data(core_out_data), .core_out_valid(core_out_valid),
      .core_out_last(core_out_last), .core_out_ready(core_out_ready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .exp_beats(exp_beats), .flush(flush), .err_clr(err_clr),
      .len_err(len_err), .beat_cnt(beat_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: plain queues of {last,data} words plus frame bookkeeping.
   logic [DATA_W:0] qin [NUM_IN][$];
   logic [DATA_W:0] qout [$];
   int unsigned     mcnt [NUM_IN];
   bit              merr [NUM_IN];
   bit              mbusy;
   bit              mrdy;
   bit              acc_last [NUM_IN];
   bit              acc_out_last;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_IN; i++) begin
         qin[i].delete();
         mcnt[i] = 0;
         merr[i] = 1'b0;
      end
      qout.delete();
      mbusy = 1'b0;
      mrdy  = 1'b0;
   endtask

   // One clock: check outputs at the falling edge, advance the model at the rising edge.
   task automatic step();
      bit acc [NUM_IN];
      bit pop [NUM_IN];
      bit acc_o, pop_o, exp_rdy, exp_v, any, bad;
      int unsigned n;
      @(negedge clk);
      for (int i = 0; i < NUM_IN; i++) begin
         exp_rdy = mrdy && !flush && (qin[i].size() < IN_DEPTH);
         exp_v   = !flush && (qin[i].size() > 0);
         chk("s_axis_tready", s_axis_tready[i], exp_rdy);
         chk("core_in_valid", core_in_valid[i], exp_v);
         if (exp_v) chk("core_in_word", {core_in_last[i], core_in_data[i]}, qin[i][0]);
         chk("beat_cnt", beat_cnt[i], mcnt[i]);
         chk("len_err", len_err[i], merr[i]);
         acc[i] = resetn && s_axis_tvalid[i] && exp_rdy;
         pop[i] = resetn && core_in_ready[i] && exp_v;
      end
      exp_rdy = mrdy && !flush && (qout.size() < OUT_DEPTH);
      exp_v   = !flush && (qout.size() > 0);
      chk("core_out_ready", core_out_ready, exp_rdy);
      chk("m_axis_tvalid", m_axis_tvalid, exp_v);
      if (exp_v) chk("m_axis_word", {m_axis_tlast, m_axis_tdata}, qout[0]);
      else       chk("m_axis_tlast_idle", m_axis_tlast, 1'b0);
      chk("busy", busy, mbusy);
      acc_o = resetn && core_out_valid && exp_rdy;
      pop_o = resetn && m_axis_tready && exp_v;

      @(posedge clk);
      if (!resetn) begin
         model_reset();
         for (int i = 0; i < NUM_IN; i++) acc_last[i] = 1'b0;
         acc_out_last = 1'b0;
      end else begin
         any = (qout.size() > 0);
         for (int i = 0; i < NUM_IN; i++) any |= (qin[i].size() > 0);
         for (int i = 0; i < NUM_IN; i++) begin
            bad = 1'b0;
            if (flush) begin
               qin[i].delete();
               mcnt[i] = 0;
            end else begin
               if (pop[i]) void'(qin[i].pop_front());
               if (acc[i]) begin
                  qin[i].push_back({s_axis_tlast[i], s_axis_tdata[i]});
                  n = mcnt[i] + 1;
                  if (s_axis_tlast[i]) begin
                     bad = (exp_beats[i] != 0) && (n != exp_beats[i]);
                     mcnt[i] = 0;
                  end else begin
                     bad = (exp_beats[i] != 0) && (n == exp_beats[i]);
                     mcnt[i] = (n > 65535) ? 65535 : n;
                  end
               end
            end
            if (bad) merr[i] = 1'b1;
            else if (err_clr) merr[i] = 1'b0;
            acc_last[i] = acc[i] && !flush;
         end
         if (flush) qout.delete();
         else begin
            if (pop_o) void'(qout.pop_front());
            if (acc_o) qout.push_back({core_out_last, core_out_data});
         end
         acc_out_last = acc_o && !flush;
         mbusy = any;
         mrdy  = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      s_axis_tvalid  = '0;
      s_axis_tlast   = '0;
      core_in_ready  = '0;
      core_out_valid = 1'b0;
      core_out_last  = 1'b0;
      m_axis_tready  = 1'b0;
      flush          = 1'b0;
      err_clr        = 1'b0;
   endtask

   task automatic send_beat(input int ch, input logic [DATA_W-1:0] d, input bit last);
      int t = 0;
      s_axis_tvalid[ch] = 1'b1;
      s_axis_tdata[ch]  = d;
      s_axis_tlast[ch]  = last;
      do begin
         step();
         t++;
      end while (!acc_last[ch] && t < 50);
      if (!acc_last[ch]) chk("send_timeout", 1'b0, 1'b1);
      s_axis_tvalid[ch] = 1'b0;
      s_axis_tlast[ch]  = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      bit any;
      core_in_ready = '1;
      m_axis_tready = 1'b1;
      do begin
         step();
         t++;
         any = (qout.size() > 0);
         for (int i = 0; i < NUM_IN; i++) any |= (qin[i].size() > 0);
      end while (any && t < 100);
      if (any) chk("drain_timeout", 1'b0, 1'b1);
   endtask

   task automatic random_phase(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         if (c % 200 == 0)
            for (int i = 0; i < NUM_IN; i++) exp_beats[i] = CNT_W'($urandom_range(0, 5));
         for (int i = 0; i < NUM_IN; i++) begin
            s_axis_tvalid[i] = ($urandom_range(0, 3) != 0);
            s_axis_tdata[i]  = {$urandom, $urandom};
            s_axis_tlast[i]  = ($urandom_range(0, 3) == 0);
            core_in_ready[i] = ($urandom_range(0, 2) != 0);
         end
         core_out_valid = ($urandom_range(0, 2) != 0);
         core_out_data  = {$urandom, $urandom};
         core_out_last  = ($urandom_range(0, 3) == 0);
         m_axis_tready  = ($urandom_range(0, 2) != 0);
         flush          = ($urandom_range(0, 63) == 0);
         err_clr        = ($urandom_range(0, 31) == 0);
         step();
      end
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit pat [4];
      int sent, t;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      s_axis_tdata  = '0;
      core_out_data = '0;
      exp_beats     = '0;
      idle_inputs();
      model_reset();
      for (int i = 0; i < NUM_IN; i++) acc_last[i] = 1'b0;
      acc_out_last = 1'b0;

      // Reset held, then released; readies must rise one edge later.
      repeat (3) step();
      resetn = 1'b1;
      repeat (2) step();

      // Ch0 fills while the core stalls, then drains in order; ch1 stays ready.
      send_beat(0, 64'h11, 1'b0);
      send_beat(0, 64'h22, 1'b0);
      send_beat(0, 64'h33, 1'b0);
      send_beat(0, 64'h44, 1'b1);
      repeat (2) step();
      drain();

      // Length check: a 4-beat frame against exp=3, clear, then a conforming frame.
      exp_beats[0] = 16'd3;
      core_in_ready = '1;
      for (int b = 0; b < 4; b++) send_beat(0, DATA_W'(64'hA0 + b), b == 3);
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      for (int b = 0; b < 3; b++) send_beat(0, DATA_W'(64'hB0 + b), b == 2);
      repeat (2) step();
      exp_beats = '0;
      drain();

      // Output path with a stalling downstream.
      idle_inputs();
      sent = 0;
      t = 0;
      while ((sent < 6 || qout.size() > 0) && t < 100) begin
         m_axis_tready  = pat[t % 4];
         core_out_valid = (sent < 6);
         core_out_data  = DATA_W'(64'hC00 + sent);
         core_out_last  = (sent == 5);
         step();
         if (acc_out_last) sent++;
         t++;
      end
      if (sent < 6 || qout.size() > 0) chk("out_timeout", 1'b0, 1'b1);
      idle_inputs();

      // Flush with three words parked in ch1 and a beat offered during flush.
      for (int b = 0; b < 3; b++) send_beat(1, DATA_W'(64'hD0 + b), 1'b0);
      flush = 1'b1;
      s_axis_tvalid[1] = 1'b1;
      s_axis_tdata[1]  = 64'hDEAD;
      step();
      flush = 1'b0;
      s_axis_tvalid[1] = 1'b0;
      core_in_ready = '1;
      repeat (3) step();

      random_phase(1500);
      drain();

      // Asynchronous reset mid-frame with two words buffered.
      idle_inputs();
      send_beat(0, 64'hE1, 1'b0);
      send_beat(0, 64'hE2, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_tready", s_axis_tready, '0);
      chk("rst_cin_valid", core_in_valid, '0);
      chk("rst_cout_ready", core_out_ready, 1'b0);
      chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_m_tlast", m_axis_tlast, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_beat_cnt", beat_cnt, '0);
      chk("rst_len_err", len_err, '0);
      model_reset();
      repeat (2) step();
      resetn = 1'b1;
      repeat (3) step();
      random_phase(400);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axis_mldsa_stream_bridge.md
Name: axis_mldsa_stream_bridge

Overview:
- Parametrised successor of the fixed two-input AXI-Stream wrapper in front of the ML-DSA core.
- Generalises to NUM_IN independent slave stream channels and a configurable data width.
- Every stream path, inputs and output, is buffered in its own FIFO.
- Adds per-channel beat counting, frame-length checking with sticky error flags, and a synchronous flush driven from the AXI4-Lite register block.

Parameters:
- DATA_W, 64, stream and core data width in bits.
- NUM_IN, 2, number of input channels to the core (1..8).
- IN_DEPTH, 4, entries per input FIFO (power of two, ≥2).
- OUT_DEPTH, 4, entries in the output FIFO (power of two, ≥2).
- CNT_W, 16, width of the beat counters and expected-length fields.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_IN*DATA_W  slave data; channel i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  NUM_IN  per-channel valid.
- s_axis_tlast  in  NUM_IN  per-channel last.
- s_axis_tready  out  NUM_IN  per-channel ready.
- core_in_data  out  NUM_IN*DATA_W  data to the core.
- core_in_valid  out  NUM_IN  valid to the core.
- core_in_last  out  NUM_IN  last to the core.
- core_in_ready  in  NUM_IN  ready from the core.
- core_out_data  in  DATA_W  core result data.
- core_out_valid  in  1  core result valid.
- core_out_last  in  1  core result last.
- core_out_ready  out  1  ready to the core.
- m_axis_tdata  out  DATA_W  master output data.
- m_axis_tvalid  out  1  master output valid.
- m_axis_tlast  out  1  master output last.
- m_axis_tready  in  1  master output ready.
- exp_beats  in  NUM_IN*CNT_W  expected beats per frame per channel; 0 disables the check.
- flush  in  1  synchronous clear of FIFOs and counters.
- err_clr  in  1  clears len_err.
- len_err  out  NUM_IN  sticky frame-length error per channel.
- beat_cnt  out  NUM_IN*CNT_W  beats accepted in the current frame per channel.
- busy  out  1  high while any FIFO is non-empty.

Behaviour:
- Reset (resetn=0, asynchronous):
  - All FIFOs empty; all counters 0; len_err=0.
  - s_axis_tready=0, core_in_valid=0, core_out_ready=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0.
  - Ready outputs rise on the first clock edge after reset is released.
- Input FIFO i:
  - Push when s_axis_tvalid[i] & s_axis_tready[i]; the stored word is {tlast, tdata}.
  - s_axis_tready[i] = !full_i. There is no bypass when full, so a simultaneous push and pop is impossible while full.
  - Pop when core_in_valid[i] & core_in_ready[i]; core_in_valid[i] = !empty_i.
  - Latency: a word accepted at edge k is presented to the core from cycle k+1.
  - Simultaneous push and pop while non-empty and non-full: occupancy is unchanged and order is preserved.
  - Pointers wrap modulo IN_DEPTH; full/empty is resolved with an extra pointer bit.
- Output FIFO:
  - Same rules as the input FIFOs, applied core→m_axis.
  - Holds {core_out_last, core_out_data}; core_out_ready = !full; m_axis_tvalid = !empty.
  - m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
- Beat counter i (counts slave-side accepts only):
  - On each accept: if tlast, beat_cnt resets to 0; otherwise beat_cnt increments by 1.
  - Saturates at 2^CNT_W−1.
- Length check (only when exp_beats[i] ≠ 0):
  - Let n = beat_cnt+1 at the accept.
  - tlast with n ≠ exp_beats sets len_err[i].
  - No tlast with n = exp_beats also sets len_err[i].
  - Data is always forwarded unmodified; errors are report-only.
- len_err is sticky until err_clr=1 (cleared next edge). err_clr and a new error in the same cycle: the error wins and len_err stays 1.
- flush=1 at an edge:
  - Empties all FIFOs and zeroes beat_cnt; len_err is unaffected.
  - While flush=1, all s_axis_tready, core_out_ready, core_in_valid and m_axis_tvalid are forced to 0.
  - Any beat presented during flush is not accepted.
- busy = OR of all FIFO non-empty flags, registered (1-cycle lag).
- Channels are fully independent; back-pressure on one channel never stalls another.

Test Plan:
- Reset release, NUM_IN=2, IN_DEPTH=4 → cycle after: tready=2'b11, core_in_valid=0, m_axis_tvalid=0, len_err=0.
- Ch0: 4 beats 0x11..0x44 with tlast on the 4th, core_in_ready=0 → tready[0] falls after the 4th accept. Release ready → core sees 0x11,0x22,0x33,0x44 with last only on 0x44; ch1 tready stays 1 throughout.
- exp_beats[0]=3, send 4-beat frame → len_err[0]=1 at the 3rd accept. err_clr → 0. Then a 3-beat frame → len_err stays 0, beat_cnt returns to 0.
- Core drives 6 results with m_axis_tready toggling 1,0,0,1 → m_axis emits all 6 in order, data held while stalled, tlast on the 6th only; core_out_ready=0 exactly when the output FIFO holds 4.
- Fill ch1 with 3 words, pulse flush → next cycle core_in_valid[1]=0, beat_cnt[1]=0, busy=0 one cycle later; the beat offered during flush is absent downstream.
- Assert resetn=0 mid-frame with 2 words buffered → outputs clear immediately without a clock edge; after release no stale data appears.
